hdmi_timing_ctrl: RTL and testbench

//  Video timing controller sequencing the three TMDS channel encoders. Generates hsync/vsync/de
//  (encoder c0/c1/de), requests pixels from the pattern source one cycle ahead and gates RGB into
//  the encoders. Sits between pixel source (colorbar/ROM) and the 3x TMDS encode + serializer.

---
 rtl/hdmi_timing_pkg.sv | 29 ++
 rtl/hdmi_phase_cnt.sv | 77 +++++++
 rtl/hdmi_timing_ctrl.sv | 140 ++++++++++++++
 tb/tb_hdmi_timing_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_pkg.sv
// Purpose: shared types and default 640x480@60 timing for the HDMI timing controller.
//   phase_t       : the four phases of one line (H) or one frame (V).
//   DEF_*         : default timing lengths in pixel clocks (H) or lines (V).
//   DEF_*_TOTAL   : pixel clocks per line / lines per frame.
//   DEF_*_START   : first active column / row, counted from the start of sync.
package hdmi_timing_pkg;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_t;

  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BACK  = 48;
  localparam int unsigned DEF_H_VALID = 640;
  localparam int unsigned DEF_H_FRONT = 16;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BACK  = 33;
  localparam int unsigned DEF_V_VALID = 480;
  localparam int unsigned DEF_V_FRONT = 10;

  localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_VALID + DEF_H_FRONT;
  localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_VALID + DEF_V_FRONT;
  localparam int unsigned DEF_H_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_START = DEF_V_SYNC + DEF_V_BACK;

endpackage

// File: rtl/hdmi_phase_cnt.sv
// Purpose: one axis of the video timing (line or frame). Four-phase FSM
//   SYNC->BACK->ACTIVE->FRONT with a per-phase counter and an absolute
//   position counter.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous return to origin (SYNC, counters 0)
//   i_step         : advance one position this cycle
//   o_phase        : current phase
//   o_pos          : absolute position within the line/frame
//   o_wrap         : this step leaves the last FRONT position (combinational)
module hdmi_phase_cnt
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned LEN_SYNC   = 1,
  parameter int unsigned LEN_BACK   = 1,
  parameter int unsigned LEN_ACTIVE = 1,
  parameter int unsigned LEN_FRONT  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_step,
  output phase_t     o_phase,
  output logic [9:0] o_pos,
  output logic       o_wrap
);

  localparam logic [9:0] LAST_SYNC   = 10'(LEN_SYNC - 1);
  localparam logic [9:0] LAST_BACK   = 10'(LEN_BACK - 1);
  localparam logic [9:0] LAST_ACTIVE = 10'(LEN_ACTIVE - 1);
  localparam logic [9:0] LAST_FRONT  = 10'(LEN_FRONT - 1);

  phase_t     r_phase;
  logic [9:0] r_cnt;
  logic [9:0] r_pos;
  logic [9:0] w_last_cnt;
  phase_t     w_next_phase;
  logic       w_phase_end;

  always_comb begin
    w_last_cnt   = LAST_SYNC;
    w_next_phase = PH_BACK;
    case (r_phase)
      PH_SYNC:   begin w_last_cnt = LAST_SYNC;   w_next_phase = PH_BACK;   end
      PH_BACK:   begin w_last_cnt = LAST_BACK;   w_next_phase = PH_ACTIVE; end
      PH_ACTIVE: begin w_last_cnt = LAST_ACTIVE; w_next_phase = PH_FRONT;  end
      PH_FRONT:  begin w_last_cnt = LAST_FRONT;  w_next_phase = PH_SYNC;   end
      default:   begin w_last_cnt = LAST_SYNC;   w_next_phase = PH_BACK;   end
    endcase
  end

  assign w_phase_end = (r_cnt == w_last_cnt);
  assign o_wrap      = i_step && w_phase_end && (r_phase == PH_FRONT);
  assign o_phase     = r_phase;
  assign o_pos       = r_pos;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= PH_SYNC;
      r_cnt   <= '0;
      r_pos   <= '0;
    end else if (i_clr) begin
      r_phase <= PH_SYNC;
      r_cnt   <= '0;
      r_pos   <= '0;
    end else if (i_step) begin
      if (w_phase_end) begin
        r_phase <= w_next_phase;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 10'd1;
      end
      r_pos <= o_wrap ? '0 : r_pos + 10'd1;
    end
  end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Purpose: video timing controller feeding three TMDS encoders. Produces
//   registered hsync/vsync/de/frame_start, requests pixels one cycle ahead
//   of de and gates source RGB onto the encoder data bus.
// Ports:
//   sys_clk, sys_rst_n : pixel clock, async active-low reset
//   enable             : 1 = run; 0 = hold at frame origin with idle outputs
//   pix_data_in        : {R,G,B} from the source, one cycle after pix_req
//   pix_req, pix_x/y   : pixel request and its coordinates (0 when idle)
//   hsync, vsync, de   : encoder c0 / c1 / de
//   rgb_out            : pix_data_in while de, else 0
//   frame_start        : one-cycle pulse at position (0,0)
module hdmi_timing_ctrl
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_VALID  = DEF_H_VALID,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_VALID  = DEF_V_VALID,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic [23:0] pix_data_in,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb_out,
  output logic        frame_start
);

  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  // Request window is the active window shifted one column earlier.
  localparam logic [9:0] REQ_FIRST = 10'(H_START - 1);
  localparam logic [9:0] REQ_LAST  = 10'(H_START + H_VALID - 2);
  localparam logic [9:0] V_OFFSET  = 10'(V_START);

  phase_t     w_h_phase;
  phase_t     w_v_phase;
  logic [9:0] w_h_pos;
  logic [9:0] w_v_pos;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_clr;
  logic       w_req;

  logic       r_origin;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_de;
  logic       r_frame_start;
  logic       r_req;
  logic [9:0] r_x;
  logic [9:0] r_y;

  assign w_clr = !enable;

  hdmi_phase_cnt #(
    .LEN_SYNC   (H_SYNC),
    .LEN_BACK   (H_BACK),
    .LEN_ACTIVE (H_VALID),
    .LEN_FRONT  (H_FRONT)
  ) u_h_cnt (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_clr   (w_clr),
    .i_step  (1'b1),
    .o_phase (w_h_phase),
    .o_pos   (w_h_pos),
    .o_wrap  (w_h_wrap)
  );

  hdmi_phase_cnt #(
    .LEN_SYNC   (V_SYNC),
    .LEN_BACK   (V_BACK),
    .LEN_ACTIVE (V_VALID),
    .LEN_FRONT  (V_FRONT)
  ) u_v_cnt (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_clr   (w_clr),
    .i_step  (w_h_wrap),
    .o_phase (w_v_phase),
    .o_pos   (w_v_pos),
    .o_wrap  (w_v_wrap)
  );

  // H_SYNC >= 1 keeps the lookahead column inside the current line.
  assign w_req = (w_v_phase == PH_ACTIVE) && (w_h_pos >= REQ_FIRST) && (w_h_pos <= REQ_LAST);

  // r_origin tracks "counters sit at (0,0)" so frame_start needs no wide compare.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_origin      <= 1'b1;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_req         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
    end else if (!enable) begin
      r_origin      <= 1'b1;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_req         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
    end else begin
      r_origin      <= w_v_wrap;
      r_hsync       <= (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_de          <= (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);
      r_frame_start <= r_origin;
      r_req         <= w_req;
      r_x           <= w_req ? (w_h_pos - REQ_FIRST) : '0;
      r_y           <= w_req ? (w_v_pos - V_OFFSET) : '0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign frame_start = r_frame_start;
  assign pix_req     = r_req;
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign rgb_out     = r_de ? pix_data_in : '0;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
module tb_hdmi_timing_ctrl;

  localparam int HS = 2, HB = 3, HV = 8, HF = 2;
  localparam int VS = 2, VB = 2, VV = 4, VF = 1;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;
  localparam logic POL = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] pix_data_in;
  logic        pix_req;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb_out;
  logic        frame_start;

  always #5 clk = ~clk;

  hdmi_timing_ctrl #(
    .H_SYNC   (HS),
    .H_BACK   (HB),
    .H_VALID  (HV),
    .H_FRONT  (HF),
    .V_SYNC   (VS),
    .V_BACK   (VB),
    .V_VALID  (VV),
    .V_FRONT  (VF),
    .SYNC_POL (POL)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .enable      (enable),
    .pix_data_in (pix_data_in),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb_out     (rgb_out),
    .frame_start (frame_start)
  );

  typedef struct {
    logic       hs, vs, de, fs, req;
    logic [9:0] x, y, dx, dy;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n = 0;  // enabled cycles since origin

  function automatic exp_t idle_exp();
    exp_t e;
    e.hs = ~POL; e.vs = ~POL; e.de = 1'b0; e.fs = 1'b0; e.req = 1'b0;
    e.x = '0; e.y = '0; e.dx = '0; e.dy = '0;
    return e;
  endfunction

  // Pixel source: echoes the requested coordinates one cycle later, random
  // tag in the top nibble; drives garbage when nothing is requested.
  always @(posedge clk) begin
    if (pix_req) pix_data_in <= {4'($urandom), pix_x, pix_y};
    else         pix_data_in <= 24'($urandom);
  end

  // Reference model: position is the enabled-cycle count folded by line/frame length.
  always @(posedge clk) begin
    exp_t e;
    int h, v, nh;
    bit hact, vact;
    if (!rst_n || !enable) begin
      e = idle_exp();
      n = 0;
    end else begin
      h    = n % HT;
      v    = (n / HT) % VT;
      nh   = h + 1;
      hact = (h >= HST) && (h < HST + HV);
      vact = (v >= VST) && (v < VST + VV);
      e.hs = (h < HS) ? POL : ~POL;
      e.vs = (v < VS) ? POL : ~POL;
      e.de = hact && vact;
      e.fs = (h == 0) && (v == 0);
      e.req = vact && (nh >= HST) && (nh < HST + HV);
      e.x  = e.req ? 10'(nh - HST) : 10'd0;
      e.y  = e.req ? 10'(v - VST) : 10'd0;
      e.dx = 10'(h - HST);
      e.dy = 10'(v - VST);
      n++;
    end
    q.push_back(e);
  end

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [23:0] er;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!rst_n) e = idle_exp();  // async reset overrides anything predicted at the edge
      er = e.de ? {pix_data_in[23:20], e.dx, e.dy} : 24'h0;
      vectors++;
      chk("hsync", {23'h0, hsync}, {23'h0, e.hs});
      chk("vsync", {23'h0, vsync}, {23'h0, e.vs});
      chk("de", {23'h0, de}, {23'h0, e.de});
      chk("frame_start", {23'h0, frame_start}, {23'h0, e.fs});
      chk("pix_req", {23'h0, pix_req}, {23'h0, e.req});
      chk("pix_x", {14'h0, pix_x}, {14'h0, e.x});
      chk("pix_y", {14'h0, pix_y}, {14'h0, e.y});
      chk("rgb_out", rgb_out, er);
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    pix_data_in = '0;
    cycles(4);
    rst_n = 1'b1;
    enable = 1'b0;
    cycles(3);
    enable = 1'b1;
    cycles(2 * HT * VT + 20);

    for (int i = 0; i < 8; i++) begin
      cycles($urandom_range(5, 300));
      enable = 1'b0;
      cycles($urandom_range(1, 3));
      enable = 1'b1;
    end

    // abort mid-active-line, then restart from origin
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
    cycles((VST + 2) * HT + HST + 4);
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
    cycles(HT * VT + 5);

    // async reset mid-active-line
    enable = 1'b0;
    cycles(1);
    enable = 1'b1;
    cycles((VST + 1) * HT + HST + 3);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2 * HT * VT + 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
